// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin front end sharing one iterative divider.
// Handles divide-by-zero locally and times out a divider that never answers.
module divider_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic [NUM_REQ-1:0]       resp_valid_out,
  output logic [WIDTH-1:0]         resp_quotient_out,
  output logic [WIDTH-1:0]         resp_remainder_out,
  output logic                     resp_error_out,
  output logic [WIDTH-1:0]         div_dividend_out,
  output logic [WIDTH-1:0]         div_divisor_out,
  output logic                     div_valid_out,
  input  logic [WIDTH-1:0]         div_quotient_in,
  input  logic [WIDTH-1:0]         div_remainder_in,
  input  logic                     div_valid_in,
  input  logic                     div_error_in,
  input  logic                     div_busy_in,
  output logic                     busy_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     owner;
  logic [CW-1:0]     cnt;

  logic              grant_hit;
  logic [PW-1:0]     grant_idx;
  logic [WIDTH-1:0]  pick_dvd;
  logic [WIDTH-1:0]  pick_dvs;
  logic              accept;
  logic              timed_out;
  logic [PW-1:0]     ptr_next;

  function automatic logic [NUM_REQ-1:0] onehot(
    input logic [PW-1:0] i
  );
    return NUM_REQ'(1) << i;
  endfunction

  // First asserted requester at or after ptr, wrapping around.
  always_comb begin : pick_winner
    int idx;
    grant_hit = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      if (req_valid_in[PW'(idx)]) begin
        grant_hit = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin : pick_operands
    pick_dvd = '0;
    pick_dvs = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == grant_idx) begin
        pick_dvd = req_dividend_in[i*WIDTH +: WIDTH];
        pick_dvs = req_divisor_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant only while the divider is free to take a new start.
  always_comb begin : decide
    accept    = grant_hit && !div_busy_in;
    timed_out = (cnt == CW'(TIMEOUT - 1));
    ptr_next  = (owner == PW'(NUM_REQ - 1))
              ? '0 : owner + 1'b1;
  end

  assign busy_out = (state != S_IDLE);

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state              <= S_IDLE;
      ptr                <= '0;
      owner              <= '0;
      cnt                <= '0;
      req_ready_out      <= '0;
      resp_valid_out     <= '0;
      resp_quotient_out  <= '0;
      resp_remainder_out <= '0;
      resp_error_out     <= 1'b0;
      div_dividend_out   <= '0;
      div_divisor_out    <= '0;
      div_valid_out      <= 1'b0;
    end else begin
      req_ready_out  <= '0;
      resp_valid_out <= '0;
      div_valid_out  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            owner         <= grant_idx;
            req_ready_out <= onehot(grant_idx);
            if (pick_dvs == '0) begin
              // Divide-by-zero never reaches the divider.
              resp_valid_out     <= onehot(grant_idx);
              resp_quotient_out  <= '1;
              resp_remainder_out <= pick_dvd;
              resp_error_out     <= 1'b1;
              state              <= S_DONE;
            end else begin
              div_dividend_out <= pick_dvd;
              div_divisor_out  <= pick_dvs;
              div_valid_out    <= 1'b1;
              cnt              <= '0;
              state            <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (div_valid_in) begin
            resp_valid_out     <= onehot(owner);
            resp_quotient_out  <= div_quotient_in;
            resp_remainder_out <= div_remainder_in;
            resp_error_out     <= div_error_in;
            state              <= S_DONE;
          end else if (timed_out) begin
            // Hung divider: give up and report an error.
            resp_valid_out     <= onehot(owner);
            resp_quotient_out  <= '0;
            resp_remainder_out <= '0;
            resp_error_out     <= 1'b1;
            state              <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          ptr   <= ptr_next;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: directed bench with a 32-cycle divider model.
// Expected results are hand-computed constants.
module tb_divider_arbiter;

  localparam int N   = 3;
  localparam int W   = 32;
  localparam int LAT = 32;

  logic           clk_in;
  logic           rst_in;
  logic [N-1:0]   req_valid_in;
  logic [N*W-1:0] req_dividend_in;
  logic [N*W-1:0] req_divisor_in;
  logic [N-1:0]   req_ready_out;
  logic [N-1:0]   resp_valid_out;
  logic [W-1:0]   resp_quotient_out;
  logic [W-1:0]   resp_remainder_out;
  logic           resp_error_out;
  logic [W-1:0]   div_dividend_out;
  logic [W-1:0]   div_divisor_out;
  logic           div_valid_out;
  logic [W-1:0]   div_quotient_in;
  logic [W-1:0]   div_remainder_in;
  logic           div_valid_in;
  logic           div_error_in;
  logic           div_busy_in;
  logic           busy_out;

  int checks;
  int errors;
  int nstart;
  int inj_req;
  int inj_done;
  bit hang;

  divider_arbiter #(
    .NUM_REQ(N),
    .WIDTH  (W),
    .TIMEOUT(64)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .req_valid_in      (req_valid_in),
    .req_dividend_in   (req_dividend_in),
    .req_divisor_in    (req_divisor_in),
    .req_ready_out     (req_ready_out),
    .resp_valid_out    (resp_valid_out),
    .resp_quotient_out (resp_quotient_out),
    .resp_remainder_out(resp_remainder_out),
    .resp_error_out    (resp_error_out),
    .div_dividend_out  (div_dividend_out),
    .div_divisor_out   (div_divisor_out),
    .div_valid_out     (div_valid_out),
    .div_quotient_in   (div_quotient_in),
    .div_remainder_in  (div_remainder_in),
    .div_valid_in      (div_valid_in),
    .div_error_in      (div_error_in),
    .div_busy_in       (div_busy_in),
    .busy_out          (busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int i,
                         input logic [W-1:0] dvd,
                         input logic [W-1:0] dvs);
    req_dividend_in[i*W +: W] = dvd;
    req_divisor_in[i*W +: W]  = dvs;
  endtask

  task automatic wait_ready(input int lim, output int n);
    n = 0;
    tick();
    n++;
    while (req_ready_out == '0 && n < lim) begin
      tick();
      n++;
    end
    check("ready_seen", 64'(req_ready_out != '0), 64'd1);
  endtask

  task automatic wait_resp(input int lim, output int n);
    n = 0;
    while (resp_valid_out == '0 && n < lim) begin
      tick();
      n++;
    end
    check("resp_seen", 64'(resp_valid_out != '0), 64'd1);
  endtask

  // Divider model: fixed latency, optional hang, stray-pulse injection.
  initial begin : div_model
    bit   pend;
    int   mcnt;
    logic [W-1:0] mq;
    logic [W-1:0] mr;
    pend = 0;
    mcnt = 0;
    mq = '0;
    mr = '0;
    inj_done = 0;
    div_valid_in = 1'b0;
    div_error_in = 1'b0;
    div_quotient_in = '0;
    div_remainder_in = '0;
    forever begin
      tick();
      div_valid_in = 1'b0;
      if (!rst_in) begin
        pend = 0;
      end else if (inj_req != inj_done) begin
        inj_done++;
        div_valid_in = 1'b1;
        div_quotient_in = 32'hDEAD;
        div_remainder_in = 32'hBEEF;
      end else if (div_valid_out && !hang) begin
        pend = 1;
        mcnt = LAT;
        mq = div_dividend_out / div_divisor_out;
        mr = div_dividend_out % div_divisor_out;
      end else if (pend) begin
        mcnt--;
        if (mcnt == 0) begin
          pend = 0;
          div_valid_in = 1'b1;
          div_quotient_in = mq;
          div_remainder_in = mr;
        end
      end
    end
  end

  initial begin : start_mon
    nstart = 0;
    forever begin
      tick();
      if (div_valid_out)
        nstart++;
    end
  end

  initial begin : main
    int n;
    int s0;
    int seen;
    logic [N-1:0] qexp [3];
    checks = 0;
    errors = 0;
    inj_req = 0;
    hang = 0;
    rst_in = 1'b0;
    req_valid_in = '0;
    req_dividend_in = '0;
    req_divisor_in = '0;
    div_busy_in = 1'b0;
    repeat (3) tick();
    check("rst_outs",
          {req_ready_out, resp_valid_out, resp_error_out,
           div_valid_out, busy_out, resp_quotient_out},
          64'd0);
    rst_in = 1'b1;
    tick();

    // Round robin with all three continuously valid.
    set_req(0, 10, 3);
    set_req(1, 20, 6);
    set_req(2, 9, 9);
    req_valid_in = 3'b111;
    qexp[0] = 3'b001;
    qexp[1] = 3'b010;
    qexp[2] = 3'b100;
    for (int k = 0; k < 3; k++) begin
      wait_ready(200, n);
      check("rr_ready", req_ready_out, qexp[k]);
      if (k == 2)
        req_valid_in = '0;
      wait_resp(200, n);
      check("rr_resp", resp_valid_out, qexp[k]);
      check("rr_q", resp_quotient_out, (k == 2) ? 1 : 3);
      check("rr_r", resp_remainder_out,
            (k == 0) ? 1 : (k == 1) ? 2 : 0);
    end
    req_valid_in = 3'b101;
    wait_ready(200, n);
    check("wrap_ready", req_ready_out, 3'b001);
    req_valid_in = '0;
    wait_resp(200, n);
    check("wrap_q", resp_quotient_out, 3);
    tick();

    // Requester 1 alone, 100/7.
    s0 = nstart;
    set_req(1, 100, 7);
    req_valid_in = 3'b010;
    wait_ready(20, n);
    check("t1_ready", req_ready_out, 3'b010);
    check("t1_start", div_valid_out, 1);
    req_valid_in = '0;
    tick();
    check("t1_ready_1cyc", req_ready_out, 0);
    check("t1_start_1cyc", div_valid_out, 0);
    wait_resp(200, n);
    check("t1_resp", resp_valid_out, 3'b010);
    check("t1_q", resp_quotient_out, 14);
    check("t1_r", resp_remainder_out, 2);
    check("t1_err", resp_error_out, 0);
    tick();
    check("t1_resp_1cyc", resp_valid_out, 0);
    check("t1_busy", busy_out, 0);
    check("t1_hold_q", resp_quotient_out, 14);
    check("t1_nstart", nstart - s0, 1);

    // Requester 2, divide by zero.
    s0 = nstart;
    set_req(2, 55, 0);
    req_valid_in = 3'b100;
    wait_ready(20, n);
    check("dz_ready", req_ready_out, 3'b100);
    check("dz_resp", resp_valid_out, 3'b100);
    check("dz_q", resp_quotient_out, 32'hFFFF_FFFF);
    check("dz_r", resp_remainder_out, 55);
    check("dz_err", resp_error_out, 1);
    req_valid_in = '0;
    repeat (3) tick();
    check("dz_nostart", nstart - s0, 0);
    check("dz_busy", busy_out, 0);

    // Hung divider: timeout, then a stray late result.
    hang = 1;
    set_req(0, 5, 1);
    req_valid_in = 3'b001;
    wait_ready(20, n);
    req_valid_in = '0;
    wait_resp(200, n);
    check("to_cycles", n, 64);
    check("to_resp", resp_valid_out, 3'b001);
    check("to_q", resp_quotient_out, 0);
    check("to_r", resp_remainder_out, 0);
    check("to_err", resp_error_out, 1);
    hang = 0;
    inj_req++;
    seen = 0;
    repeat (6) begin
      tick();
      if (resp_valid_out != '0)
        seen++;
    end
    check("stray_ignored", seen, 0);
    check("stray_busy", busy_out, 0);

    // Divider busy blocks grants.
    div_busy_in = 1'b1;
    set_req(0, 12, 4);
    req_valid_in = 3'b001;
    seen = 0;
    repeat (10) begin
      tick();
      if (req_ready_out != '0)
        seen++;
    end
    check("busy_nogrant", seen, 0);
    div_busy_in = 1'b0;
    wait_ready(20, n);
    check("busy_grant_lat", n, 1);
    req_valid_in = '0;
    wait_resp(200, n);
    check("busy_q", resp_quotient_out, 3);
    tick();

    // Reset in the middle of WAIT.
    set_req(1, 50, 5);
    req_valid_in = 3'b010;
    wait_ready(20, n);
    req_valid_in = '0;
    repeat (3) tick();
    check("mid_busy", busy_out, 1);
    rst_in = 1'b0;
    #1;
    check("mid_rst_a",
          {req_ready_out, resp_valid_out, resp_error_out,
           div_valid_out, busy_out, resp_quotient_out},
          64'd0);
    check("mid_rst_b",
          {resp_remainder_out, div_dividend_out}, 64'd0);
    check("mid_rst_c", div_divisor_out, 0);
    repeat (2) tick();
    rst_in = 1'b1;
    tick();
    set_req(0, 8, 2);
    set_req(2, 9, 3);
    req_valid_in = 3'b101;
    wait_ready(20, n);
    check("post_ready", req_ready_out, 3'b001);
    req_valid_in = '0;
    wait_resp(200, n);
    check("post_resp", resp_valid_out, 3'b001);
    check("post_q", resp_quotient_out, 4);
    check("post_r", resp_remainder_out, 0);
    check("post_err", resp_error_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
